seq_mul: RTL and testbench
==========================

# seq_mul

Parametrised sequential shift-add multiplier. It is the multi-cycle successor to the 4-bit combinational `mul` in the arithmetic ops group. It computes a full-width product of two WIDTH-bit operands in either unsigned or two's-complement signed mode. A start/busy/done handshake lets a controller issue back-to-back operations, trading latency for a single adder of WIDTH+1 bits.

## Interface
Parameters:
- WIDTH, default 4: operand width in bits; legal range 2..32; product is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only while idle (busy=0).
- signed_mode  input  1  1 = two's-complement operands and product, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; product valid and updated this cycle.
- product  output  2*WIDTH  result register; holds its value until the next done.

## Operation
- States: IDLE, RUN, SIGN.
- IDLE:
  - On start=1, latch |a| and |b| as WIDTH-bit unsigned magnitudes. In unsigned mode the magnitudes are the raw values.
  - Latch result sign = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the accumulator and iteration counter, then go to RUN.
- RUN, one iteration per cycle:
  - If multiplier LSB = 1, add the multiplicand magnitude into the upper half of the 2*WIDTH accumulator with carry (a WIDTH+1-bit sum).
  - Shift accumulator and multiplier right by one.
  - After exactly WIDTH iterations, go to SIGN.
- SIGN:
  - product <= sign ? -(accumulator) : accumulator, computed mod 2^(2*WIDTH).
  - Assert done, return to IDLE.
- Most-negative operand: its magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits. The product is exact for all operand pairs in both modes. For example, WIDTH=4, -8*-8 = +64.
- Zero result with sign=1 yields 0. No negative-zero artefact.
- start while busy=1 is ignored. Operands and mode changing during RUN have no effect.
- start asserted in the same cycle as done is accepted, because the state is IDLE.
- Reset:
  - Asynchronously forces state=IDLE, busy=0, done=0, product=0, and clears the accumulator and counter.
  - Reset mid-operation aborts it. No done is produced for the aborted operation.

## Timing
- Edge E0 samples start in IDLE. busy=1 from after E0.
- Edges E1..EWIDTH perform the WIDTH iterations. State is SIGN after EWIDTH.
- Edge EWIDTH+1 writes product and sets done=1 and busy=0 for one cycle.
- Latency from the start-sampling edge to done: WIDTH+1 cycles.
- Minimum issue interval: WIDTH+2 cycles, for start held high or re-asserted during the done cycle.
- done is never high for two consecutive cycles.
- busy and done are never high together.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Unsigned, WIDTH=4: a=0011, b=0101, signed_mode=0, start pulse -> done exactly 5 cycles later, product=0x0F. Then a=1111, b=0001 -> product=0x0F.
- Unsigned extremes, WIDTH=4: 15*15 -> product=0xE1. Repeat with a WIDTH=8 instance: 255*255 -> product=0xFE01. Check done latency is 9 cycles.
- Signed, WIDTH=4:
  - a=1000, b=1000 -> product=0x40.
  - a=1111, b=0111 -> product=0xF9 (-7).
  - a=0000, b=1001 -> product=0x00.
- Handshake:
  - Start 3*5, pulse start again with 2*2 two cycles later -> only one done, product=0x0F.
  - Start held high continuously -> done every 6 cycles, busy low only during the done cycles.
- Reset: start 7*7, assert rst on the 3rd cycle of RUN -> busy=0, done=0, product=0 immediately. No done follows. A new start of 2*3 then gives product=0x06 after 5 cycles.

Source files
------------

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: WIDTH iterations on operand magnitudes,
// then a sign fix-up cycle. Handles unsigned and two's-complement operands.
module seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic               sign_reg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_neg;

    // The most-negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    always_comb begin
        a_mag   = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag   = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
        addend  = mplier_reg[0] ? mcand_reg : '0;
        sum     = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_neg = ~acc_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            sign_reg   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            product    <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg  <= a_mag;
                        mplier_reg <= b_mag;
                        sign_reg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        busy       <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    // Carry out of the upper-half add lands in the MSB after the shift.
                    acc_reg    <= {sum, acc_reg[WIDTH-1:1]};
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ITER) begin
                        state_reg <= SIGN;
                    end
                end
                SIGN: begin
                    product   <= sign_reg ? acc_neg : acc_reg;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: directed vectors on WIDTH=4 and WIDTH=8
// instances, monitors compare product and start-to-done latency.
module tb_seq_mul;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic       start4 = 1'b0, mode4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4;
    logic [7:0] prod4;

    logic        start8 = 1'b0, mode8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;

    exp_t q4[$];
    exp_t q8[$];
    logic prev_done4 = 1'b0;
    logic prev_done8 = 1'b0;

    seq_mul #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(mode4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
    );

    seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(mode8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    // Monitors: pop an expectation on every done and compare
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done4) begin
            checks++;
            if (busy4 || prev_done4) begin
                errors++;
                $display("FAIL w4_done_shape busy=%0b prev_done=%0b required busy=0 prev_done=0", busy4, prev_done4);
            end
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL w4_unexpected_done product=%h required no done", prod4);
            end else begin
                e = q4.pop_front();
                if (prod4 !== e.prod[7:0] || (cyc - e.cyc) != 5) begin
                    errors++;
                    $display("FAIL w4_result product=%h latency=%0d required product=%h latency=5", prod4, cyc - e.cyc, e.prod[7:0]);
                end else
                    $display("w4 done product=%h latency=%0d", prod4, cyc - e.cyc);
            end
        end
        prev_done4 = rst ? 1'b0 : done4;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done8) begin
            checks++;
            if (busy8 || prev_done8) begin
                errors++;
                $display("FAIL w8_done_shape busy=%0b prev_done=%0b required busy=0 prev_done=0", busy8, prev_done8);
            end
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL w8_unexpected_done product=%h required no done", prod8);
            end else begin
                e = q8.pop_front();
                if (prod8 !== e.prod || (cyc - e.cyc) != 9) begin
                    errors++;
                    $display("FAIL w8_result product=%h latency=%0d required product=%h latency=9", prod8, cyc - e.cyc, e.prod);
                end else
                    $display("w8 done product=%h latency=%0d", prod8, cyc - e.cyc);
            end
        end
        prev_done8 = rst ? 1'b0 : done8;
    end

    task automatic wait_idle4();
        int n = 0;
        while (busy4 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (busy4) begin
            checks++; errors++;
            $display("FAIL w4_idle_timeout busy=1 required 0");
        end
    endtask

    task automatic issue4(input logic m, input logic [3:0] x, input logic [3:0] y,
                          input logic [7:0] expv, input bit push);
        wait_idle4();
        mode4 = m; a4 = x; b4 = y; start4 = 1'b1;
        @(posedge clk); #1;
        if (push) q4.push_back('{prod: {8'h00, expv}, cyc: cyc});
        $display("w4 issue mode=%0b a=%h b=%h expect=%h", m, x, y, expv);
        start4 = 1'b0;
    endtask

    task automatic issue8(input logic m, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] expv);
        int n = 0;
        while (busy8 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        mode8 = m; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        q8.push_back('{prod: expv, cyc: cyc});
        $display("w8 issue mode=%0b a=%h b=%h expect=%h", m, x, y, expv);
        start8 = 1'b0;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else
            $display("%s ok value=%h", name, act);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_w4", {6'd0, busy4, done4, prod4}, 16'h0000);
        check("reset_w8", {busy8, done8, 14'd0} | prod8, 16'h0000);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned WIDTH=4
        issue4(1'b0, 4'h3, 4'h5, 8'h0F, 1);
        issue4(1'b0, 4'hF, 4'h1, 8'h0F, 1);
        issue4(1'b0, 4'hF, 4'hF, 8'hE1, 1);
        // Signed WIDTH=4
        issue4(1'b1, 4'h8, 4'h8, 8'h40, 1);
        issue4(1'b1, 4'hF, 4'h7, 8'hF9, 1);
        issue4(1'b1, 4'h0, 4'h9, 8'h00, 1);
        issue4(1'b1, 4'h7, 4'h8, 8'hC8, 1);
        issue4(1'b1, 4'h8, 4'h1, 8'hF8, 1);

        // WIDTH=8
        issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
        issue8(1'b1, 8'h80, 8'h80, 16'h4000);
        issue8(1'b1, 8'hFF, 8'h01, 16'hFFFF);

        // start pulsed while busy must be ignored
        issue4(1'b0, 4'h3, 4'h5, 8'h0F, 1);
        @(posedge clk); #1;
        a4 = 4'h2; b4 = 4'h2; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;

        // start held high: back-to-back every 6 cycles
        wait_idle4();
        mode4 = 1'b0; a4 = 4'h3; b4 = 4'h5; start4 = 1'b1;
        @(posedge clk); #1;
        q4.push_back('{prod: 16'h000F, cyc: cyc});
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("held_busy_xor_done", {15'd0, busy4 ^ done4}, 16'h0001);
            @(posedge clk); #1;
            if (i == 6 || i == 12) q4.push_back('{prod: 16'h000F, cyc: cyc});
        end
        start4 = 1'b0;

        // Reset in the 3rd RUN cycle aborts with no done
        issue4(1'b0, 4'h7, 4'h7, 8'h31, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_w4", {6'd0, busy4, done4, prod4}, 16'h0000);
        @(negedge clk) rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        issue4(1'b0, 4'h2, 4'h3, 8'h06, 1);

        // Drain scoreboards with a bounded wait
        for (int n = 0; n < 100 && (q4.size() != 0 || q8.size() != 0); n++)
            @(posedge clk);
        #1;
        check("drain_q4", 16'(q4.size()), 16'h0000);
        check("drain_q8", 16'(q8.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
